// File: rtl/snn_kron_core.sv
// Spiking core with T blocks of N integer neurons and Kronecker-structured weights.
// Spikes are integrated one (source, target block) pair per cycle, and the result is dumped on AXI4-Stream.
module snn_kron_core #(
  parameter int T      = 4,
  parameter int N      = 4,
  parameter int TA     = $clog2(T),
  parameter int ALPHA  = 128,
  parameter int NN     = 16,
  parameter int NU     = $clog2(N),
  parameter int THRESH = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 time_step,
  input  logic                 force_spike_en,
  input  logic [TA-1:0]        force_spike_block_select,
  input  logic [$clog2(N)-1:0] force_spike_neuron_select,
  input  logic                 select,
  output logic                 axis_out_tvalid,
  input  logic                 axis_out_tready,
  output logic [NN-1:0]        axis_out_tdata,
  output logic [NU-1:0]        axis_out_tuser,
  output logic                 axis_out_tlast
);

  localparam int NT = T * N;
  localparam int SW = $clog2(NT);

  if (ALPHA < T * T * N + 4) begin : g_alpha_check
    $error("snn_kron_core: ALPHA shorter than one accumulation pass");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_WAIT_END,
    ST_THRESH,
    ST_STREAM
  } state_t;

  state_t          state, state_next;
  logic [NN-1:0]   pot       [T][N];
  logic            pending   [T][N];
  logic            spikes    [T][N];
  logic            fired     [T][N];
  logic            force_hit [T][N];
  logic            armed;
  logic            sel_q;
  logic [SW-1:0]   src;
  logic [SW-1:0]   beat;
  logic [TA-1:0]   tgt;
  logic [TA-1:0]   src_blk, beat_blk;
  logic [NU-1:0]   src_nrn, beat_nrn;
  logic [NN:0]     acc_sum   [N];
  logic [NN-1:0]   acc_val   [N];
  logic            start, accum_done, last_beat;

  assign start      = (state == ST_IDLE) && time_step && armed;
  assign accum_done = (src == SW'(NT - 1)) && (tgt == TA'(T - 1));
  assign last_beat  = (beat == SW'(NT - 1));

  // Source coordinates, the saturating weight adds for the current target block, and force decoding.
  always_comb begin
    src_blk  = TA'(int'(src) / N);
    src_nrn  = NU'(int'(src) % N);
    beat_blk = TA'(int'(beat) / N);
    beat_nrn = NU'(int'(beat) % N);
    for (int j = 0; j < N; j++) begin
      acc_sum[j] = {1'b0, pot[tgt][j]}
                 + (NN+1)'((int'(src_blk) + int'(tgt) + 1) * (int'(src_nrn) + j + 1));
      acc_val[j] = acc_sum[j][NN] ? {NN{1'b1}} : acc_sum[j][NN-1:0];
    end
    for (int b = 0; b < T; b++) begin
      for (int j = 0; j < N; j++) begin
        force_hit[b][j] = force_spike_en
                        && (force_spike_block_select == TA'(b))
                        && (force_spike_neuron_select == NU'(j));
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_ACCUM;
      ST_ACCUM:    if (accum_done) state_next = ST_WAIT_END;
      ST_WAIT_END: if (!time_step) state_next = ST_THRESH;
      ST_THRESH:   state_next = ST_STREAM;
      ST_STREAM:   if (axis_out_tready && last_beat) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Payload is derived only from registers, so tready never reaches tvalid combinationally.
  always_comb begin
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    axis_out_tdata  = '0;
    axis_out_tuser  = '0;
    if (state == ST_STREAM) begin
      axis_out_tvalid = 1'b1;
      axis_out_tlast  = last_beat;
      axis_out_tuser  = beat_nrn;
      axis_out_tdata  = sel_q ? NN'(fired[beat_blk][beat_nrn]) : pot[beat_blk][beat_nrn];
    end
  end

  // Armed is preset at reset so the first step after reset can start without a low time_step first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int b = 0; b < T; b++) begin
        for (int j = 0; j < N; j++) begin
          pot[b][j]     <= '0;
          pending[b][j] <= 1'b0;
          spikes[b][j]  <= 1'b0;
          fired[b][j]   <= 1'b0;
        end
      end
      armed <= 1'b1;
      sel_q <= 1'b0;
      src   <= '0;
      tgt   <= '0;
      beat  <= '0;
    end else begin
      if (!time_step) armed <= 1'b1;
      if (start) begin
        armed <= 1'b0;
        src   <= '0;
        tgt   <= '0;
      end
      if (state == ST_ACCUM) begin
        if (tgt == TA'(T - 1)) begin
          tgt <= '0;
          src <= src + 1'b1;
        end else begin
          tgt <= tgt + 1'b1;
        end
      end
      if (state == ST_THRESH) begin
        sel_q <= select;
        beat  <= '0;
      end
      if (state == ST_STREAM && axis_out_tready) beat <= beat + 1'b1;
      for (int b = 0; b < T; b++) begin
        for (int j = 0; j < N; j++) begin
          if (force_hit[b][j]) pending[b][j] <= 1'b1;
          if (start) begin
            spikes[b][j]  <= pending[b][j] | force_hit[b][j];
            pending[b][j] <= 1'b0;
          end
          if (state == ST_ACCUM && tgt == TA'(b) && spikes[src_blk][src_nrn])
            pot[b][j] <= acc_val[j];
          if (state == ST_THRESH) begin
            if (pot[b][j] >= NN'(THRESH)) begin
              pot[b][j]     <= '0;
              pending[b][j] <= 1'b1;
              fired[b][j]   <= 1'b1;
            end else begin
              fired[b][j] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_kron_core.sv
// Self-checking bench for snn_kron_core: constant vector table, directed multi-step sequences,
// and randomized steps compared against an arithmetic reference of the potentials and pending spikes.
module tb_snn_kron_core;

  localparam int T      = 4;
  localparam int N      = 4;
  localparam int TA     = 2;
  localparam int NU     = 2;
  localparam int NN     = 16;
  localparam int ALPHA  = 128;
  localparam int THRESH = 64;
  localparam int NT     = T * N;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          time_step;
  logic          force_spike_en;
  logic [TA-1:0] force_spike_block_select;
  logic [NU-1:0] force_spike_neuron_select;
  logic          select;
  logic          tvalid;
  logic          tready;
  logic [NN-1:0] tdata;
  logic [NU-1:0] tuser;
  logic          tlast;

  snn_kron_core #(.T(T), .N(N), .ALPHA(ALPHA), .NN(NN), .THRESH(THRESH)) dut (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .time_step                 (time_step),
    .force_spike_en            (force_spike_en),
    .force_spike_block_select  (force_spike_block_select),
    .force_spike_neuron_select (force_spike_neuron_select),
    .select                    (select),
    .axis_out_tvalid           (tvalid),
    .axis_out_tready           (tready),
    .axis_out_tdata            (tdata),
    .axis_out_tuser            (tuser),
    .axis_out_tlast            (tlast)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference state: potentials, pending spikes and last fired flags.
  int mv     [T][N];
  int mpend  [NT];
  int mfired [NT];
  int captured [NT];

  typedef struct {
    int t;
    int n;
    int b;
    int j;
    int exp_v;
  } vec_t;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < T; b++)
      for (int j = 0; j < N; j++) mv[b][j] = 0;
    for (int k = 0; k < NT; k++) begin
      mpend[k]  = 0;
      mfired[k] = 0;
    end
  endfunction

  function automatic void model_accum(input int spk [NT]);
    for (int s = 0; s < NT; s++) begin
      if (spk[s] != 0) begin
        for (int b = 0; b < T; b++) begin
          for (int j = 0; j < N; j++) begin
            mv[b][j] = mv[b][j] + (s / N + b + 1) * (s % N + j + 1);
            if (mv[b][j] > 65535) mv[b][j] = 65535;
          end
        end
      end
    end
  endfunction

  function automatic void model_thresh();
    for (int b = 0; b < T; b++) begin
      for (int j = 0; j < N; j++) begin
        if (mv[b][j] >= THRESH) begin
          mv[b][j]       = 0;
          mpend[b*N+j]   = 1;
          mfired[b*N+j]  = 1;
        end else begin
          mfired[b*N+j]  = 0;
        end
      end
    end
  endfunction

  function automatic int exp_beat(input int k, input bit sel);
    return sel ? mfired[k] : mv[k/N][k%N];
  endfunction

  task automatic apply_reset();
    aresetn        = 1'b0;
    time_step      = 1'b0;
    force_spike_en = 1'b0;
    tready         = 1'b0;
    select         = 1'b0;
    force_spike_block_select  = '0;
    force_spike_neuron_select = '0;
    @(posedge aclk); #1;
    check_output("reset_tvalid", int'(tvalid), 0);
    check_output("reset_tlast", int'(tlast), 0);
    check_output("reset_tdata", int'(tdata), 0);
    check_output("reset_tuser", int'(tuser), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    model_reset();
  endtask

  task automatic force_idle(input int b, input int j);
    force_spike_block_select  = TA'(b);
    force_spike_neuron_select = NU'(j);
    force_spike_en = 1'b1;
    @(posedge aclk); #1;
    force_spike_en = 1'b0;
    mpend[b*N+j] = 1;
  endtask

  // rmode: 0 = always ready, 1 = ready every other cycle, 2 = random ready.
  task automatic consume_stream(input int rmode, input int abort_at, input bit sel);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    bit held = 1'b0;
    bit aborted = 1'b0;
    int held_word = 0;
    while (idx < NT && cyc < 300 && !aborted) begin
      case (rmode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 2 == 1);
        default: tready = ($urandom_range(0, 1) == 1);
      endcase
      if (tvalid && first < 0) begin
        first = cyc;
        check_output("first_valid_cycle", cyc, 2);
      end
      if (held)
        check_output($sformatf("stall_stable_beat%0d", idx),
                     int'({tvalid, tlast, tuser, tdata}), held_word);
      if (abort_at == idx && tvalid) begin
        aresetn = 1'b0;
        #1;
        check_output("abort_tvalid", int'(tvalid), 0);
        check_output("abort_tlast", int'(tlast), 0);
        check_output("abort_tdata", int'(tdata), 0);
        aborted = 1'b1;
      end else if (tvalid && tready) begin
        captured[idx] = int'(tdata);
        check_output($sformatf("beat%0d_data", idx), int'(tdata), exp_beat(idx, sel));
        check_output($sformatf("beat%0d_user", idx), int'(tuser), idx % N);
        check_output($sformatf("beat%0d_last", idx), int'(tlast), (idx == NT - 1) ? 1 : 0);
        idx++;
        held = 1'b0;
      end else begin
        held = tvalid;
        held_word = int'({1'b1, tlast, tuser, tdata});
      end
      if (!aborted) begin
        @(posedge aclk); #1;
        cyc++;
      end
    end
    tready = 1'b0;
    if (aborted) begin
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      model_reset();
    end else begin
      check_output("beats_received", idx, NT);
      check_output("idle_after_last", int'(tvalid), 0);
    end
  endtask

  task automatic apply_stimulus(input bit fen, input int fb, input int fn, input bit sel,
                                input int rmode, input bit extra, input int abort_at);
    int spk [NT];
    int rb;
    int rj;
    for (int k = 0; k < NT; k++) begin
      spk[k]   = mpend[k];
      mpend[k] = 0;
    end
    if (fen) spk[fb*N+fn] = 1;
    select    = sel;
    time_step = 1'b1;
    force_spike_en            = fen;
    force_spike_block_select  = TA'(fb);
    force_spike_neuron_select = NU'(fn);
    @(posedge aclk); #1;
    force_spike_en = 1'b0;
    for (int c = 1; c < ALPHA; c++) begin
      force_spike_en = 1'b0;
      if (extra && $urandom_range(0, 19) == 0) begin
        rb = int'($urandom_range(0, T - 1));
        rj = int'($urandom_range(0, N - 1));
        force_spike_block_select  = TA'(rb);
        force_spike_neuron_select = NU'(rj);
        force_spike_en = 1'b1;
        mpend[rb*N+rj] = 1;
      end
      if (c == ALPHA - 1) check_output("no_valid_during_step", int'(tvalid), 0);
      @(posedge aclk); #1;
    end
    force_spike_en = 1'b0;
    time_step      = 1'b0;
    model_accum(spk);
    model_thresh();
    consume_stream(rmode, abort_at, sel);
  endtask

  initial begin
    vec_t tbl [7];
    tbl = '{'{0, 0, 3, 3, 16}, '{0, 0, 0, 0, 1},  '{3, 3, 3, 3, 49},
            '{1, 2, 0, 0, 6},  '{2, 1, 1, 3, 20}, '{3, 0, 2, 1, 12},
            '{0, 3, 3, 0, 16}};

    apply_reset();

    // Single forced spike from a fresh reset: spot-check potentials against hand-computed weights.
    for (int v = 0; v < 7; v++) begin
      apply_reset();
      apply_stimulus(1'b1, tbl[v].t, tbl[v].n, 1'b0, 0, 1'b0, -1);
      check_output($sformatf("table%0d_v", v), captured[tbl[v].b*N+tbl[v].j], tbl[v].exp_v);
    end

    // Every single-source position; random readout selection (nothing fires, so flags read 0).
    for (int t = 0; t < T; t++) begin
      for (int n = 0; n < N; n++) begin
        apply_reset();
        apply_stimulus(1'b1, t, n, bit'($urandom_range(0, 1)), 0, 1'b0, -1);
      end
    end

    // Backpressure on every other cycle.
    apply_reset();
    apply_stimulus(1'b1, 0, 0, 1'b0, 1, 1'b0, -1);
    check_output("bp_v33", captured[15], 16);

    // Two accumulations of (3,3) push several neurons over threshold, then they propagate.
    apply_reset();
    apply_stimulus(1'b1, 3, 3, 1'b0, 0, 1'b0, -1);
    check_output("two_step_first_v33", captured[15], 49);
    apply_stimulus(1'b1, 3, 3, 1'b1, 0, 1'b0, -1);
    check_output("two_step_flag33", captured[15], 1);
    check_output("two_step_flag22", captured[10], 1);
    check_output("two_step_flag00", captured[0], 0);
    apply_stimulus(1'b0, 0, 0, 1'b0, 1, 1'b0, -1);

    // Reset in the middle of a dump, then a clean run.
    apply_reset();
    apply_stimulus(1'b1, 1, 2, 1'b0, 0, 1'b0, 5);
    apply_stimulus(1'b1, 0, 0, 1'b0, 0, 1'b0, -1);
    check_output("after_abort_v33", captured[15], 16);

    // Spike forced while no step runs is carried into the next step.
    apply_reset();
    force_idle(0, 0);
    apply_stimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, -1);
    check_output("idle_force_v33", captured[15], 16);
    check_output("idle_force_v10", captured[4], 2);

    // Random steps with forces before and during steps and random backpressure.
    apply_reset();
    for (int r = 0; r < 8; r++) begin
      for (int f = int'($urandom_range(0, 2)); f > 0; f--)
        force_idle(int'($urandom_range(0, T - 1)), int'($urandom_range(0, N - 1)));
      apply_stimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, T - 1)),
                     int'($urandom_range(0, N - 1)), bit'($urandom_range(0, 1)), 2, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_kron_core.md
Name: snn_kron_core

Overview:
- Small spiking-neural-network core: T blocks × N neurons, integer membrane potentials.
- Connectivity weights are Kronecker-structured and computed on the fly.
- During a time step, forced or pending spikes are integrated into every neuron's potential. After the step, all potentials (or spike flags) are streamed out on an AXI4-Stream master.
- Top-level compute block, driven by a host/sequencer and read by a stream sink.

Parameters:
- T, 4, number of neuron blocks.
- N, 4, neurons per block.
- TA, $clog2(T), block-select width.
- ALPHA, 128, nominal time-step length in cycles; must be ≥ T*T*N+4.
- NN, 16, tdata width (potential width).
- NU, $clog2(N), tuser width.
- THRESH, 64, firing threshold.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- time_step  in  1  high = time step in progress.
- force_spike_en  in  1  one-cycle strobe that forces a spike.
- force_spike_block_select  in  TA  block of the forced neuron.
- force_spike_neuron_select  in  $clog2(N)  neuron within that block.
- select  in  1  readout content: 0 = potentials, 1 = spike flags.
- axis_out.tvalid  out  1  stream valid.
- axis_out.tready  in  1  stream ready.
- axis_out.tdata  out  NN  beat payload.
- axis_out.tuser  out  NU  neuron index within block.
- axis_out.tlast  out  1  last beat of dump.

Behaviour:
- Reset (async, aresetn=0):
  - All potentials V[b][j]=0, pending[b][j]=0, spike vector cleared, state=IDLE.
  - tvalid=0, tlast=0, tdata=0, tuser=0.
  - Reset mid-stream aborts the dump immediately.
- Weight function: w(a,i→b,j) = (a+b+1)*(i+j+1), unsigned. Self-connection included.
- Forced spikes: force_spike_en=1 in any cycle sets pending[block_sel][neuron_sel]. Out-of-range block_sel is ignored.
- States: IDLE, ACCUM, WAIT_END, THRESH, STREAM.
- Step arming: an armed flag is set whenever time_step=0 is sampled.
- IDLE: when time_step=1 and armed:
  - S = pending OR (forced target, if force_spike_en is high this cycle).
  - Clear pending and armed.
  - Go to ACCUM.
- ACCUM:
  - Scan sources s = 0..T*N-1 in (block, neuron) order and target blocks b = 0..T-1.
  - One (s,b) pair per cycle. If S[s]=1, V[b][j] += w(s→b,j) for all j in parallel; otherwise skip in one cycle.
  - Additions saturate at 2^NN-1.
  - Completes in exactly T*T*N cycles, then go to WAIT_END.
- WAIT_END: wait for time_step=0, then go to THRESH.
- THRESH (1 cycle): every neuron with V≥THRESH gets pending=1 and V←0; spike flag for readout = that result. Then go to STREAM.
- STREAM:
  - Emits exactly T*N beats, block-major: b=0..T-1, j=0..N-1.
  - tdata = V[b][j] when select=0, or zero-extended fired flag when select=1. select is sampled on entry to STREAM.
  - tuser = j.
  - tlast=1 only on beat b=T-1, j=N-1.
  - AXI rules: tvalid held high, payload stable until tvalid&tready. Advance only on handshake. No combinational tready→tvalid path.
  - First beat valid the cycle after THRESH.
  - After the tlast handshake: tvalid=0, go to IDLE.
  - Potentials persist across steps; only reset clears them.
- time_step high while in STREAM: no new step starts until IDLE with armed set.
- force_spike_en during ACCUM/STREAM only sets pending; it does not affect the current step.
- Simultaneous force_spike_en on the step-start cycle: the spike is included in the current step.

Test Plan:
- Reset, force (block 0, neuron 0) with time_step high for ALPHA cycles, then tready=1 -> 16 beats: tuser = 0,1,2,3 repeating; V[b][j] = (b+1)*(j+1), e.g. V[3][3]=16. tlast on beat 16 only.
- For every (t,n) in 4×4 with reset between runs -> V[b][j] = (t+b+1)*(n+j+1); max case (3,3) gives V[3][3]=49; no neuron fires.
- Backpressure: tready toggled every other cycle -> same 16 beats, no drops or duplicates, payload stable while stalled.
- Two steps without reset, force (3,3) then (3,3) -> V[3][3]=49 ≥ 64? no; after second step 98 ≥ 64 -> fires, dump shows V[3][3]=0. select=1 dump shows flag 1 at beat 16. Third step without force shows the propagated pending spike.
- Assert aresetn mid-stream at beat 5 -> tvalid=0 immediately; next dump after a forced spike shows fresh values only.
- force_spike_en with time_step low, then a step with no force -> spike applied in that step (same values as first scenario).
